clk_div_bank: RTL

Parametrised bank of NUM_CH independent clock dividers, each with a runtime-programmable divisor.
Per channel it produces a one-cycle tick (clock-enable) and a square-wave clk_o that toggles on every tick.
- Divisor updates are glitch-free: a new divisor is applied only at a period boundary or while the channel is disabled.
- A global sync input phase-aligns all channels.
- Serves as the timing source for game logic, animation, debounce and display refresh, replacing the fixed-frequency single-channel divider.

---
 rtl/clk_div_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with runtime divisors.
// Each channel emits a one-cycle tick and a square wave that toggles on every tick.
module clk_div_bank #(
    parameter int unsigned     NUM_CH      = 4,
    parameter int unsigned     CNT_W       = 32,
    parameter longint unsigned DEFAULT_DIV = 50000000,
    parameter logic            IDLE_LEVEL  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_i,
    input  logic [NUM_CH-1:0]       div_load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       pending_o
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             pv_q, pv_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] div_in;
        logic [CNT_W-1:0] div_eff;
        logic             wrap;

        assign div_in  = div_i[k*CNT_W +: CNT_W];
        assign div_eff = (div_q == '0) ? CNT_W'(1) : div_q;
        assign wrap    = (cnt_q == div_eff - CNT_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            pend_d = pend_q;
            pv_d   = pv_q;
            clk_d  = clk_q;
            tick_d = 1'b0;
            if (sync_i || !en_i[k] || wrap) begin
                // Period boundary: a same-edge load wins over any older pending value.
                if (div_load_i[k]) begin
                    div_d = div_in;
                    pv_d  = 1'b0;
                end else if (pv_q) begin
                    div_d = pend_q;
                    pv_d  = 1'b0;
                end
                cnt_d = '0;
                if (sync_i || !en_i[k]) begin
                    clk_d = IDLE_LEVEL;
                end else begin
                    tick_d = 1'b1;
                    clk_d  = ~clk_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_load_i[k]) begin
                    pend_d = div_in;
                    pv_d   = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                div_q  <= DEF_D;
                pend_q <= '0;
                pv_q   <= 1'b0;
                clk_q  <= IDLE_LEVEL;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pend_q <= pend_d;
                pv_q   <= pv_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign tick_o[k]    = tick_q;
        assign clk_o[k]     = clk_q;
        assign pending_o[k] = pv_q;
    end

endmodule
